// File: rtl/axi4lite_gpreg_bridge_if.sv
// AXI4-Lite slave-side channel bundle for the GPIO register bridge.
// Only the address bits [9:2] are used downstream, so ADDR_W must be at least 10.
interface axi4lite_gpreg_bridge_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] S_AWADDR;
  logic              S_AWVALID;
  logic              S_AWREADY;
  logic [31:0]       S_WDATA;
  logic [3:0]        S_WSTRB;
  logic              S_WVALID;
  logic              S_WREADY;
  logic [1:0]        S_BRESP;
  logic              S_BVALID;
  logic              S_BREADY;
  logic [ADDR_W-1:0] S_ARADDR;
  logic              S_ARVALID;
  logic              S_ARREADY;
  logic [31:0]       S_RDATA;
  logic [1:0]        S_RRESP;
  logic              S_RVALID;
  logic              S_RREADY;

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    input  S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    output S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    output S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/axi4lite_gpreg_bridge.sv
// AXI4-Lite slave to single-cycle GPIO register bus, one transaction in flight.
// Write: AW&W accepted -> strobe next cycle -> BVALID 3 cycles later; read: AR -> RVALID 3 cycles later.
module axi4lite_gpreg_bridge #(
  parameter int ADDR_W = 10
) (
  input  logic                     iCLK,
  input  logic                     iRSTN,
  axi4lite_gpreg_bridge_if.slave   s,
  output logic [7:0]               oWADR,
  output logic                     oWR,
  output logic [31:0]              oWDAT,
  output logic [7:0]               oRADR,
  input  logic [31:0]              iRDAT,
  input  logic                     iERR
);

  typedef enum logic [2:0] {
    IDLE, WR_STB, WR_CHK, WR_RSP, RD_STB, RD_CAP, RD_RSP
  } state_e;

  state_e      state_q, state_d;
  logic        live_q;
  logic        aw_held_q, w_held_q;
  logic [3:0]  wstrb_q;
  logic        strb_err_q;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q;
  logic        rr_pri_q;
  logic [7:0]  wadr_q, radr_q;
  logic [31:0] wdat_q;

  logic aw_rdy, w_rdy, ar_rdy;
  logic aw_hs, w_hs, ar_hs;

  logic [ADDR_W-1:0] unused_addr;
  assign unused_addr = s.S_AWADDR ^ s.S_ARADDR;

  always_comb begin
    state_d = state_q;
    aw_rdy  = 1'b0;
    w_rdy   = 1'b0;
    ar_rdy  = 1'b0;
    // live_q keeps every READY low while reset is applied and for the first cycle after
    if (state_q == IDLE && live_q) begin
      aw_rdy = !aw_held_q;
      w_rdy  = !w_held_q;
      ar_rdy = !aw_held_q && !w_held_q && !((s.S_AWVALID || s.S_WVALID) && !rr_pri_q);
    end
    aw_hs = aw_rdy && s.S_AWVALID;
    w_hs  = w_rdy  && s.S_WVALID;
    ar_hs = ar_rdy && s.S_ARVALID;

    case (state_q)
      IDLE: begin
        if (ar_hs)
          state_d = RD_STB;
        else if ((aw_held_q || aw_hs) && (w_held_q || w_hs))
          state_d = WR_STB;
      end
      WR_STB:  state_d = WR_CHK;
      WR_CHK:  state_d = WR_RSP;
      WR_RSP:  if (s.S_BREADY) state_d = IDLE;
      RD_STB:  state_d = RD_CAP;
      RD_CAP:  state_d = RD_RSP;
      RD_RSP:  if (s.S_RREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q    <= IDLE;
      live_q     <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      wstrb_q    <= 4'h0;
      strb_err_q <= 1'b0;
      bresp_q    <= 2'b00;
      rdata_q    <= 32'h0;
      rr_pri_q   <= 1'b0;
      wadr_q     <= 8'h0;
      radr_q     <= 8'h0;
      wdat_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        wadr_q    <= s.S_AWADDR[9:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdat_q   <= s.S_WDATA;
        wstrb_q  <= s.S_WSTRB;
      end
      if (ar_hs)
        radr_q <= s.S_ARADDR[9:2];
      if (state_q == WR_STB)
        strb_err_q <= (wstrb_q != 4'hF);
      if (state_q == WR_CHK)
        bresp_q <= {iERR || strb_err_q, 1'b0};
      if (state_q == WR_RSP && s.S_BREADY) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        rr_pri_q  <= 1'b1;
      end
      if (state_q == RD_CAP)
        rdata_q <= iRDAT;
      if (state_q == RD_RSP && s.S_RREADY)
        rr_pri_q <= 1'b0;
    end
  end

  // The core has no byte enables, so partial writes never strobe
  assign oWR   = (state_q == WR_STB) && (wstrb_q == 4'hF);
  assign oWADR = wadr_q;
  assign oWDAT = wdat_q;
  assign oRADR = radr_q;

  assign s.S_AWREADY = aw_rdy;
  assign s.S_WREADY  = w_rdy;
  assign s.S_ARREADY = ar_rdy;
  assign s.S_BVALID  = (state_q == WR_RSP);
  assign s.S_BRESP   = bresp_q;
  assign s.S_RVALID  = (state_q == RD_RSP);
  assign s.S_RDATA   = rdata_q;
  assign s.S_RRESP   = 2'b00;

endmodule
